risc_prog_loader: RTL and testbench
===================================

Name: risc_prog_loader

Overview:
- Loads a program into the 16-bit RISC core's instruction memory from a byte-stream source such as a UART receiver or a bench driver.
- Drives the instruction-RAM write port, the word at each address the core fetches from via PC_addr.
- Holds the core in reset until a complete, checksum-verified image has been written, then releases it.

Parameters:
- W, 16, instruction word width in bits.
- AW, 8, instruction address width; equals W-8, matching the core's PC_addr.
- HDR, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_byte holds a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts in_byte this cycle; a transfer happens when in_valid && in_ready.
- imem_we  output  1  instruction-RAM write strobe, one cycle per word.
- imem_addr  output  AW  instruction-RAM write address.
- imem_wdata  output  W  instruction-RAM write data.
- cpu_reset  output  1  reset to the RISC core, active-high.
- done  output  1  image loaded and verified.
- err  output  1  last frame failed its checksum.
- word_count  output  AW+1  words written in the current or last frame.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_reset = 1, done = 0, err = 0, word_count = 0.
  - Internal checksum = 0, remaining-length counter = 0.
- Frame format:
  - HDR byte.
  - Length byte N, counted in words; N = 0 means 256.
  - 2N data bytes, high byte then low byte of each word.
  - One checksum byte equal to the XOR of all 2N data bytes.
- States:
  - IDLE: wait for HDR; other bytes are consumed and dropped.
  - LEN: latch the length; clear address, checksum and word_count; go to HI.
  - HI: latch the high byte; XOR it into the checksum; go to LO.
  - LO: form the word and XOR the low byte into the checksum. Register imem_wdata = {hi, lo} and imem_addr = current address. Go to WRITE.
  - WRITE: imem_we = 1 and in_ready = 0 for exactly this cycle. Increment address (wraps 8'hFF to 8'h00) and word_count. If remaining = 0, go to CSUM; otherwise go to HI.
  - CSUM: if the byte matches the checksum, go to DONE. Otherwise go to ERR.
  - DONE: done = 1, cpu_reset = 0. A new HDR goes to LEN and reasserts cpu_reset = 1, done = 0 in the following cycle.
  - ERR: err = 1, cpu_reset = 1. A new HDR goes to LEN and clears err.
- in_ready = 1 in every state except WRITE. Bytes arriving while in_valid = 0 are not sampled.
- The loader is never blocked by the downstream RAM; the RAM completes its write in one cycle.
- In DONE and ERR, non-HDR bytes are consumed and ignored.
- A byte equal to HDR in the LEN, HI, LO or CSUM states is data, not a restart.
- N = 256 writes addresses 0..255; word_count reaches 256, which is why it is AW+1 bits wide.
- Reset mid-frame: abort immediately and return to the reset values, so cpu_reset is high next cycle. Words already written stay in the RAM.
- cpu_reset is registered and glitch-free. It is low only in DONE.

Decomposition:
- Shared package risc_pkg holds:
  - W, AW.
  - Loader state encoding: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR, 3-bit.
  - The HDR constant.
- Sub-module risc_prog_loader_csum: the XOR accumulator with clear and enable inputs. It is the natural split; everything else stays in the top FSM.

Test Plan:
- Normal load: reset 2 cycles, then A5 02 12 34 AB CD 40 ->
  - Writes 0x1234 @ 0x00, then 0xABCD @ 0x01, one imem_we pulse each.
  - After the checksum byte: done = 1, cpu_reset = 0, word_count = 2.
- Bad checksum: A5 01 00 01 00 -> one write of 0x0001 @ 0x00, then err = 1, done = 0, cpu_reset held at 1.
- Reload from DONE: after the first scenario, send A5 01 FF FF 00 ->
  - cpu_reset rises the cycle after the header is accepted.
  - Writes 0xFFFF @ 0x00, then done = 1.
- Full image: A5 00, then 512 bytes with word k = k, then the matching checksum ->
  - 256 writes covering addresses 0x00..0xFF.
  - word_count = 256, done = 1.
- Backpressure and gaps: insert random in_valid = 0 gaps and hold in_valid = 1 across WRITE cycles ->
  - No byte is lost or duplicated.
  - in_ready = 0 exactly in each WRITE cycle.
- Reset mid-frame: assert reset after the HI byte of word 3 ->
  - Next cycle: state IDLE, cpu_reset = 1, imem_we = 0, word_count = 0.
  - A subsequent valid frame loads correctly.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared constants and loader state encoding for the 16-bit RISC core.
package risc_pkg;

    localparam int         W   = 16;
    localparam int         AW  = W - 8;
    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } ld_state_e;

endpackage

// File: rtl/risc_prog_loader_csum.sv
// Running XOR of the frame's data bytes; clear wins over enable.
module risc_prog_loader_csum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    // Accumulate one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/risc_prog_loader.sv
// Byte-stream program loader: parses HDR/LEN/data/checksum frames, writes the
// instruction RAM one word at a time and holds the core in reset until a
// verified image is in place.
module risc_prog_loader #(
    parameter int         W   = 16,
    parameter int         AW  = W - 8,
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    import risc_pkg::*;

    ld_state_e     state_q, state_d;
    logic          xfer;
    logic          csum_clr, csum_en;
    logic [7:0]    csum;
    logic [7:0]    hi_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   rem_q;

    // WRITE is the only cycle the loader stalls the source.
    assign in_ready = (state_q != WRITE);
    assign xfer     = in_valid && in_ready;

    risc_prog_loader_csum u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (in_byte),
        .sum   (csum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and checksum control.
    always_comb begin
        state_d  = state_q;
        csum_clr = 1'b0;
        csum_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && in_byte == HDR) state_d = LEN;
            end
            LEN: begin
                if (xfer) begin
                    csum_clr = 1'b1;
                    state_d  = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    csum_en = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    csum_en = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // rem_q was already decremented when the low byte arrived.
                state_d = (rem_q == '0) ? CSUM : HI;
            end
            CSUM: begin
                if (xfer) state_d = (in_byte == csum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (xfer && in_byte == HDR) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: length, address, word assembly and word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= 8'h00;
            addr_q     <= '0;
            rem_q      <= '0;
            word_count <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state_q)
                LEN: begin
                    if (xfer) begin
                        // A length byte of zero encodes a full 2^AW-word image.
                        rem_q      <= (in_byte == 8'h00) ? {1'b1, {AW{1'b0}}}
                                                         : (AW+1)'(in_byte);
                        addr_q     <= '0;
                        word_count <= '0;
                    end
                end
                HI: begin
                    if (xfer) hi_q <= in_byte;
                end
                LO: begin
                    if (xfer) begin
                        imem_wdata <= W'({hi_q, in_byte});
                        imem_addr  <= addr_q;
                        rem_q      <= rem_q - (AW+1)'(1);
                    end
                end
                WRITE: begin
                    addr_q     <= addr_q + AW'(1);
                    word_count <= word_count + (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered status outputs, decoded from the next state so they line up
    // with the state register and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we   <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            imem_we   <= (state_d == WRITE);
            cpu_reset <= (state_d != DONE);
            done      <= (state_d == DONE);
            err       <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader with a frame-level expectation model.
module tb_risc_prog_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] mem [256];

    risc_prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every cycle: stall only while writing, core released only when done,
    // and each write matches the next word the model predicts.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_only_low_in_write", 32'(in_ready), 32'(!imem_we));
            chk("cpu_reset_low_only_done", 32'(cpu_reset), 32'(!done));
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(imem_addr), 32'(e.a));
                    chk("write_data", 32'(imem_wdata), 32'(e.d));
                end
                mem[imem_addr] = imem_wdata;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_byte  = HDR;  // must not be sampled while in_valid is low
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Model: a well-formed frame writes word k at address k; it loads iff the
    // trailing byte equals the XOR of every data byte.
    task automatic load_frame(input logic [7:0] fr[$], input int gapmax, output bit ok);
        int         n;
        logic [7:0] x;
        wr_t        w;
        n = (fr[1] == 8'h00) ? 256 : int'(fr[1]);
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            w.a = 8'(k);
            w.d = {fr[2+2*k], fr[3+2*k]};
            exp_q.push_back(w);
            x = x ^ fr[2+2*k] ^ fr[3+2*k];
        end
        ok = (x == fr[2+2*n]);
        send(fr[0], 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("hdr_done", 32'(done), 32'd0);
        chk("hdr_err", 32'(err), 32'd0);
        for (int i = 1; i < fr.size(); i++)
            send(fr[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        go_idle();
        chk("frame_done", 32'(done), 32'(ok));
        chk("frame_err", 32'(err), 32'(!ok));
        chk("frame_cpu_reset", 32'(cpu_reset), 32'(!ok));
        chk("frame_word_count", 32'(word_count), 32'(n));
        chk("frame_writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        bit         ok;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;

        // Junk in IDLE is dropped.
        send(8'h33, 0);
        go_idle();
        chk("idle_junk_cpu_reset", 32'(cpu_reset), 32'd1);

        // Normal two-word load.
        fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        load_frame(fr, 0, ok);
        chk("normal_ok", 32'(ok), 32'd1);
        chk("normal_mem0", 32'(mem[0]), 32'h1234);
        chk("normal_mem1", 32'(mem[1]), 32'hABCD);
        chk("normal_wc", 32'(word_count), 32'd2);

        // Reload from DONE.
        chk("pre_reload_cpu_reset", 32'(cpu_reset), 32'd0);
        fr = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00};
        load_frame(fr, 0, ok);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_mem0", 32'(mem[0]), 32'hFFFF);

        // Bad checksum.
        fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00};
        load_frame(fr, 0, ok);
        chk("bad_ok", 32'(ok), 32'd0);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_mem0", 32'(mem[0]), 32'h0001);

        // Non-HDR bytes in ERR are ignored.
        send(8'h12, 0);
        send(8'h34, 1);
        go_idle();
        chk("err_junk_err", 32'(err), 32'd1);

        // HDR value used as data, with random gaps.
        fr = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5};
        load_frame(fr, 3, ok);
        chk("hdrdata_done", 32'(done), 32'd1);
        chk("hdrdata_mem0", 32'(mem[0]), 32'hA5A5);
        chk("hdrdata_mem1", 32'(mem[1]), 32'h00A5);

        // Full 256-word image, word k = k; XOR of 0..255 is 0.
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(8'h00);
        for (int k = 0; k < 256; k++) begin
            fr.push_back(8'h00);
            fr.push_back(8'(k));
        end
        fr.push_back(8'h00);
        load_frame(fr, 2, ok);
        chk("full_ok", 32'(ok), 32'd1);
        chk("full_wc", 32'(word_count), 32'd256);
        chk("full_mem80", 32'(mem[8'h80]), 32'h0080);
        chk("full_memff", 32'(mem[8'hFF]), 32'h00FF);

        // Reset after the HI byte of word 3.
        fr = '{8'hA5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        for (int k = 0; k < 3; k++) begin
            wr_t w;
            w.a = 8'(k);
            w.d = {fr[2+2*k], fr[3+2*k]};
            exp_q.push_back(w);
        end
        foreach (fr[i]) send(fr[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_imem_we", 32'(imem_we), 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_writes_left", 32'(exp_q.size()), 32'd0);
        chk("midrst_mem2", 32'(mem[2]), 32'h5566);

        // Fresh frame after reset: DE^AD^BE^EF = 22.
        fr = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        load_frame(fr, 1, ok);
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_mem0", 32'(mem[0]), 32'hDEAD);
        chk("post_rst_mem1", 32'(mem[1]), 32'hBEEF);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
